// File: rtl/bus_mux_pkg.sv
// Shared constants for the source bus multiplexer: default widths and source indices.
// Latency: none (constants and a pure helper function only).
// Backpressure: not applicable.
package bus_mux_pkg;

   localparam int BUS_DATA_W  = 32;
   localparam int BUS_NUM_SRC = 24;
   localparam int BUS_CNT_W   = 8;

   // Source index map: general registers first, then the special sources.
   localparam int SRC_R0     = 0;
   localparam int SRC_R15    = 15;
   localparam int SRC_HI     = 16;
   localparam int SRC_LO     = 17;
   localparam int SRC_ZHI    = 18;
   localparam int SRC_ZLO    = 19;
   localparam int SRC_PC     = 20;
   localparam int SRC_MDR    = 21;
   localparam int SRC_INPORT = 22;
   localparam int SRC_CSIGN  = 23;

   // One-hot enable mask for a single source index.
   function automatic logic [BUS_NUM_SRC-1:0] src_bit(input int idx);
      logic [BUS_NUM_SRC-1:0] m;
      m      = '0;
      m[idx] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/onehot_prio_enc.sv
// Lowest-index priority encoder with "none set" and "more than one set" flags.
// Latency: purely combinational.
// Backpressure: none.
module onehot_prio_enc #(
   parameter int N = 24
) (
   input  logic [N-1:0]         req,
   output logic [$clog2(N)-1:0] idx,
   output logic                 none,
   output logic                 multi
);

   localparam int IDX_W = $clog2(N);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = IDX_W'(i);
      end
   end

   // Clearing the lowest set bit leaves something only when two or more were set.
   always_comb begin
      none  = ~|req;
      multi = |(req & (req - N'(1)));
   end

endmodule

// File: rtl/bus_mux_reg.sv
// Registered source bus: picks the lowest enabled source, keeps the last value when idle, counts conflicts.
// Latency: one clock from src_out/src_in to bus_out, sel_idx, bus_valid and conflict.
// Backpressure: none; a new source is captured every cycle that any enable is set.
module bus_mux_reg
   import bus_mux_pkg::*;
#(
   parameter int DATA_W  = BUS_DATA_W,
   parameter int NUM_SRC = BUS_NUM_SRC,
   parameter int CNT_W   = BUS_CNT_W
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic [NUM_SRC*DATA_W-1:0]  src_in,
   input  logic [NUM_SRC-1:0]         src_out,
   input  logic                       err_clr,
   output logic [DATA_W-1:0]          bus_out,
   output logic                       bus_valid,
   output logic [$clog2(NUM_SRC)-1:0] sel_idx,
   output logic                       conflict,
   output logic                       conflict_flag,
   output logic [CNT_W-1:0]           conflict_cnt
);

   localparam int IDX_W = $clog2(NUM_SRC);

   logic [IDX_W-1:0]  idx;
   logic              none;
   logic              multi;
   logic [DATA_W-1:0] sel_data;

   onehot_prio_enc #(.N(NUM_SRC)) u_enc (
      .req   (src_out),
      .idx   (idx),
      .none  (none),
      .multi (multi)
   );

   // Data mux for the encoded source; index compare avoids a scaled variable part-select.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (idx == IDX_W'(i)) sel_data = src_in[i*DATA_W +: DATA_W];
      end
   end

   // Bus register: load when any source is enabled, otherwise keep the previous value.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         bus_out   <= '0;
         sel_idx   <= '0;
         bus_valid <= 1'b0;
      end else begin
         bus_valid <= ~none;
         if (!none) begin
            bus_out <= sel_data;
            sel_idx <= idx;
         end
      end
   end

   // Conflict tracking: err_clr clears first, so a coincident conflict still counts as one.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         conflict      <= 1'b0;
         conflict_flag <= 1'b0;
         conflict_cnt  <= '0;
      end else begin
         conflict <= multi;
         if (err_clr) begin
            conflict_flag <= multi;
            conflict_cnt  <= multi ? CNT_W'(1) : '0;
         end else if (multi) begin
            conflict_flag <= 1'b1;
            if (conflict_cnt != {CNT_W{1'b1}}) conflict_cnt <= conflict_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_bus_mux_reg.sv
// Scoreboard bench for bus_mux_reg: the driver queues the expected register state, a monitor checks it.
// Latency: expectations are queued at the capturing edge and compared on the following falling edge.
// Backpressure: none; the monitor consumes one expectation per cycle while the queue is non-empty.
module tb_bus_mux_reg;
   import bus_mux_pkg::*;

   localparam int DW = BUS_DATA_W;
   localparam int NS = BUS_NUM_SRC;
   localparam int CW = BUS_CNT_W;

   typedef struct {
      logic [DW-1:0] bus;
      logic          valid;
      int            idx;
      logic          conf;
      logic          flag;
      int            cnt;
   } exp_t;

   logic                  clk;
   logic                  clr;
   logic [NS*DW-1:0]      src_in;
   logic [NS-1:0]         src_out;
   logic                  err_clr;
   logic [DW-1:0]         bus_out;
   logic                  bus_valid;
   logic [$clog2(NS)-1:0] sel_idx;
   logic                  conflict;
   logic                  conflict_flag;
   logic [CW-1:0]         conflict_cnt;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   bus_mux_reg dut (
      .clk           (clk),
      .clr           (clr),
      .src_in        (src_in),
      .src_out       (src_out),
      .err_clr       (err_clr),
      .bus_out       (bus_out),
      .bus_valid     (bus_valid),
      .sel_idx       (sel_idx),
      .conflict      (conflict),
      .conflict_flag (conflict_flag),
      .conflict_cnt  (conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".bus_out"},       bus_out, 32'd0);
      check({tag, ".bus_valid"},     32'(bus_valid), 32'd0);
      check({tag, ".sel_idx"},       32'(sel_idx), 32'd0);
      check({tag, ".conflict"},      32'(conflict), 32'd0);
      check({tag, ".conflict_flag"}, 32'(conflict_flag), 32'd0);
      check({tag, ".conflict_cnt"},  32'(conflict_cnt), 32'd0);
   endtask

   task automatic set_src(input int i, input logic [DW-1:0] val);
      src_in[i*DW +: DW] = val;
   endtask

   // Drive one cycle of enables, then queue the state expected after the capturing edge.
   task automatic apply(input logic [NS-1:0] so, input logic ec,
                        input logic [DW-1:0] eb, input logic ev, input int eidx,
                        input logic econf, input logic eflag, input int ecnt);
      exp_t e;
      src_out = so;
      err_clr = ec;
      @(posedge clk);
      e.bus = eb; e.valid = ev; e.idx = eidx; e.conf = econf; e.flag = eflag; e.cnt = ecnt;
      q.push_back(e);
      #1;
   endtask

   // Monitor: compare the registered outputs against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("bus_out",       bus_out, e.bus);
            check("bus_valid",     32'(bus_valid), 32'(e.valid));
            check("sel_idx",       32'(sel_idx), 32'(e.idx));
            check("conflict",      32'(conflict), 32'(e.conf));
            check("conflict_flag", 32'(conflict_flag), 32'(e.flag));
            check("conflict_cnt",  32'(conflict_cnt), 32'(e.cnt));
         end
      end
   end

   initial begin
      clr     = 1'b0;
      err_clr = 1'b0;
      src_in  = '0;
      src_out = src_bit(5);
      for (int i = 0; i < NS; i++) set_src(i, 32'h1000_0000 + 32'(i));

      // Reset held through a rising edge with a source enabled.
      #3;
      check_zero("rst_pre_edge");
      #4;
      check_zero("rst_post_edge");
      #1;
      clr = 1'b1;

      // First capture from reset values: PC onto the bus.
      set_src(SRC_PC, 32'h0000_0100);
      apply(src_bit(SRC_PC), 1'b0, 32'h0000_0100, 1'b1, SRC_PC, 1'b0, 1'b0, 0);
      // Idle: keeper holds the value, valid drops.
      apply('0, 1'b0, 32'h0000_0100, 1'b0, SRC_PC, 1'b0, 1'b0, 0);
      // Conflict between R3 and HI: lowest index wins.
      set_src(3, 32'hAAAA_0003);
      set_src(SRC_HI, 32'h1616_1616);
      apply(src_bit(3) | src_bit(SRC_HI), 1'b0, 32'hAAAA_0003, 1'b1, 3, 1'b1, 1'b1, 1);
      // Single source next: pulse ends, flag and count stay.
      set_src(SRC_LO, 32'h0000_1717);
      apply(src_bit(SRC_LO), 1'b0, 32'h0000_1717, 1'b1, SRC_LO, 1'b0, 1'b1, 1);
      // R0 held enabled while its data changes each cycle.
      set_src(0, 32'h0000_0011);
      apply(src_bit(0), 1'b0, 32'h0000_0011, 1'b1, 0, 1'b0, 1'b1, 1);
      set_src(0, 32'h0000_0022);
      apply(src_bit(0), 1'b0, 32'h0000_0022, 1'b1, 0, 1'b0, 1'b1, 1);
      set_src(0, 32'h0000_0033);
      apply(src_bit(0), 1'b0, 32'h0000_0033, 1'b1, 0, 1'b0, 1'b1, 1);
      // err_clr alone clears the sticky state.
      apply('0, 1'b1, 32'h0000_0033, 1'b0, 0, 1'b0, 1'b0, 0);

      // Long conflict run: count saturates at 255.
      set_src(5, 32'h0000_0055);
      for (int k = 1; k <= 260; k++) begin
         apply(src_bit(5) | src_bit(SRC_CSIGN), 1'b0, 32'h0000_0055, 1'b1, 5, 1'b1, 1'b1,
               (k > 255) ? 255 : k);
      end

      // err_clr coincident with a conflict: clear then count one.
      set_src(0, 32'h0000_0A0A);
      apply(src_bit(0) | src_bit(1), 1'b1, 32'h0000_0A0A, 1'b1, 0, 1'b1, 1'b1, 1);
      apply('0, 1'b1, 32'h0000_0A0A, 1'b0, 0, 1'b0, 1'b0, 0);
      // Highest source index.
      set_src(SRC_CSIGN, 32'hC51C_0017);
      apply(src_bit(SRC_CSIGN), 1'b0, 32'hC51C_0017, 1'b1, SRC_CSIGN, 1'b0, 1'b0, 0);
      // Conflict to make the flag non-zero before the mid-run reset.
      set_src(SRC_MDR, 32'h0D0D_0021);
      apply(src_bit(SRC_MDR) | src_bit(SRC_INPORT), 1'b0, 32'h0D0D_0021, 1'b1, SRC_MDR, 1'b1, 1'b1, 1);

      // Let the monitor drain, then pull reset between edges with a capture pending.
      @(negedge clk);
      #2;
      check("queue_drained_pre_reset", 32'(q.size()), 32'd0);
      set_src(SRC_MDR, 32'hBEEF_0021);
      src_out = src_bit(SRC_MDR);
      clr = 1'b0;
      #1;
      check_zero("rst_async");
      @(posedge clk);
      #1;
      check_zero("rst_held_edge");
      #2;
      clr = 1'b1;
      // First edge after release captures from reset values.
      apply(src_bit(SRC_MDR), 1'b0, 32'hBEEF_0021, 1'b1, SRC_MDR, 1'b0, 1'b0, 0);
      apply('0, 1'b0, 32'hBEEF_0021, 1'b0, SRC_MDR, 1'b0, 1'b0, 0);

      @(negedge clk);
      #2;
      check("queue_drained_end", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_mux_reg.md
BUS_MUX_REG -- requirements
Module: bus_mux_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each source and of the bus.
REQ-002 SHALL have parameter NUM_SRC, default 24, number of bus sources (R0-R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C_sign_extended).
REQ-003 SHALL have parameter CNT_W, default 8, width of the conflict counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port clr  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have port src_in  input  NUM_SRC*DATA_W  flattened source data; source i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port src_out  input  NUM_SRC  one-hot "out" enables from the control unit; bit i requests that source i drive the bus.
REQ-008 SHALL have port err_clr  input  1  synchronous clear of conflict_flag and conflict_cnt.
REQ-009 SHALL have port bus_out  output  DATA_W  registered bus value.
REQ-010 SHALL have port bus_valid  output  1  high when bus_out was loaded on the previous edge.
REQ-011 SHALL have port sel_idx  output  $clog2(NUM_SRC)  index of the source captured in bus_out.
REQ-012 SHALL have port conflict  output  1  one-cycle pulse when more than one src_out bit was set.
REQ-013 SHALL have port conflict_flag  output  1  sticky conflict indicator.
REQ-014 SHALL have port conflict_cnt  output  CNT_W  saturating conflict count.

Function
REQ-015 SHALL encode src_out combinationally to the lowest set index and a "none" and a "multiple" indication.
REQ-016 SHALL, when at least one src_out bit is set, load bus_out with the selected slice, sel_idx with its index, and set bus_valid on the next rising edge (latency 1 cycle).
REQ-017 SHALL, when src_out is all zero, hold bus_out and sel_idx unchanged (bus keeper) and clear bus_valid on the next edge.
REQ-018 SHALL, when two or more src_out bits are set, select the lowest index, assert conflict for exactly the following cycle, and set conflict_flag.
REQ-019 SHALL increment conflict_cnt by 1 per conflict cycle and saturate at 2^CNT_W-1 without wrapping.
REQ-020 SHALL keep conflict_flag set until err_clr or reset.
REQ-021 SHALL, on err_clr with no simultaneous conflict, clear conflict_flag and conflict_cnt to 0 on the next edge.
REQ-022 SHALL, on err_clr coincident with a conflict, leave conflict_flag at 1 and conflict_cnt at 1 (clear then count).
REQ-023 SHALL treat src_out bits beyond NUM_SRC as nonexistent; sources are indexed 0..NUM_SRC-1 only.
REQ-024 SHALL sample a continuously asserted single src_out bit every cycle, so bus_out tracks changing source data with 1-cycle delay.

Reset
REQ-025 SHALL, while clr is low, force bus_out=0, bus_valid=0, sel_idx=0, conflict=0, conflict_flag=0, conflict_cnt=0 regardless of clk.
REQ-026 SHALL, on reset assertion mid-transfer, discard the pending capture; the first edge after clr rises behaves as REQ-016/017 from the reset values.

Structure
REQ-027 SHALL take DATA_W/NUM_SRC/CNT_W defaults and source index constants (SRC_R0=0 ... SRC_R15=15, SRC_HI=16, SRC_LO=17, SRC_ZHI=18, SRC_ZLO=19, SRC_PC=20, SRC_MDR=21, SRC_INPORT=22, SRC_CSIGN=23) from shared package bus_mux_pkg.
REQ-028 SHALL implement the lowest-index encoder as sub-module onehot_prio_enc (parameter N; outputs idx, none, multi).

Verification
REQ-029 SHALL cover: reset low with src_out=bit5 -> all outputs 0; release, src_out=1<<SRC_PC, PC=0x0000_0100 -> next edge bus_out=0x100, sel_idx=20, bus_valid=1.
REQ-030 SHALL cover: src_out=0 after loading 0x100 -> bus_out stays 0x100, bus_valid=0.
REQ-031 SHALL cover: src_out=bits 3 and 16, R3=0xAAAA_0003 -> bus_out=0xAAAA_0003, sel_idx=3, conflict pulse 1 cycle, conflict_flag=1, conflict_cnt=1.
REQ-032 SHALL cover: 260 consecutive conflict cycles with CNT_W=8 -> conflict_cnt=255, no wrap.
REQ-033 SHALL cover: err_clr with src_out=bits 0 and 1 on same cycle -> conflict_flag=1, conflict_cnt=1; err_clr alone next cycle -> both 0.
REQ-034 SHALL cover: clr pulsed low mid-cycle while src_out=1<<SRC_MDR -> outputs 0 immediately, no edge required.
